alu_4_bit_req_sequencer: RTL and testbench

//   Clocked initiator for the combinational alu_4_bit. Accepts operation requests over
//   a valid/ready handshake and drives A/B/AINV/BNEG/Opr onto the ALU. It waits a

---
 rtl/alu_4_bit_req_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_4_bit_req_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_4_bit_req_sequencer.sv
// alu_4_bit_req_sequencer
//   Clocked initiator for the combinational alu_4_bit. A request accepted on the
//   req_* valid/ready port is registered onto alu_*. The operands are held for a
//   settle time, then the ALU outputs are captured into rsp_*. Add/subtract results
//   are compared against a 5-bit golden model, and the result is returned on the
//   rsp_* valid/ready port.
// Ports
//   Clk, Resetb           clock; synchronous active-low reset
//   req_valid/req_ready   request handshake; req_A/B/AINV/BNEG/Opr = operation
//   alu_A/B/AINV/BNEG/Opr registered drive to alu_4_bit
//   alu_RESULT/OVERFLOW/ZERO/COUT  ALU outputs
//   rsp_valid/rsp_ready   response handshake; rsp_RESULT/OVERFLOW/ZERO/COUT captured
//   rsp_checked           operation was compared against the golden model
//   rsp_mismatch          checked, and a captured field differs from the model
//   test_count            completed transactions (saturating)
//   error_count           completed transactions with a mismatch (saturating)
module alu_4_bit_req_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             Clk,
  input  logic             Resetb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_A,
  input  logic [3:0]       req_B,
  input  logic             req_AINV,
  input  logic             req_BNEG,
  input  logic [1:0]       req_Opr,
  output logic [3:0]       alu_A,
  output logic [3:0]       alu_B,
  output logic             alu_AINV,
  output logic             alu_BNEG,
  output logic [1:0]       alu_Opr,
  input  logic [3:0]       alu_RESULT,
  input  logic             alu_OVERFLOW,
  input  logic             alu_ZERO,
  input  logic             alu_COUT,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_RESULT,
  output logic             rsp_OVERFLOW,
  output logic             rsp_ZERO,
  output logic             rsp_COUT,
  output logic             rsp_checked,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] error_count
);

  // A settle time of 0 would skip the capture edge, so it is raised to 1.
  localparam int unsigned   SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned   SW          = $clog2(SETTLE_EFF + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_EFF);
  localparam logic [SW-1:0] CNT_ONE     = SW'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;

  logic [4:0] gold_sum;
  logic       gold_v;
  logic       gold_z;
  logic       chk;
  logic       mis;

  assign req_ready = (state == IDLE) & Resetb;
  assign rsp_valid = (state == RESP);

  // Golden model evaluated on the operands currently held on the ALU.
  always_comb begin
    gold_sum = '0;
    gold_v   = 1'b0;
    if (alu_BNEG) begin
      gold_sum = {1'b0, alu_A} + {1'b0, ~alu_B} + 5'd1;
      gold_v   = (alu_A[3] != alu_B[3]) && (gold_sum[3] != alu_A[3]);
    end else begin
      gold_sum = {1'b0, alu_A} + {1'b0, alu_B};
      gold_v   = (alu_A[3] == alu_B[3]) && (gold_sum[3] != alu_A[3]);
    end
    gold_z = (gold_sum[3:0] == 4'd0);
    chk    = (alu_Opr == 2'd2) && !alu_AINV;
    mis    = chk && ((alu_RESULT != gold_sum[3:0]) || (alu_OVERFLOW != gold_v) ||
                     (alu_ZERO != gold_z) || (alu_COUT != gold_sum[4]));
  end

  always_ff @(posedge Clk) begin
    if (!Resetb) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_AINV     <= 1'b0;
      alu_BNEG     <= 1'b0;
      alu_Opr      <= '0;
      rsp_RESULT   <= '0;
      rsp_OVERFLOW <= 1'b0;
      rsp_ZERO     <= 1'b0;
      rsp_COUT     <= 1'b0;
      rsp_checked  <= 1'b0;
      rsp_mismatch <= 1'b0;
      test_count   <= '0;
      error_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_A      <= req_A;
            alu_B      <= req_B;
            alu_AINV   <= req_AINV;
            alu_BNEG   <= req_BNEG;
            alu_Opr    <= req_Opr;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == CNT_ONE) begin
            rsp_RESULT   <= alu_RESULT;
            rsp_OVERFLOW <= alu_OVERFLOW;
            rsp_ZERO     <= alu_ZERO;
            rsp_COUT     <= alu_COUT;
            rsp_checked  <= chk;
            rsp_mismatch <= mis;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            if (test_count != '1) test_count <= test_count + 1'b1;
            if (rsp_mismatch && (error_count != '1)) error_count <= error_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_4_bit_req_sequencer.sv
// Bench for alu_4_bit_req_sequencer: a behavioural 4-bit ALU is attached to each
// instance. Expected responses are hand-computed constants queued at issue time and
// popped by a monitor on each response handshake.
module tb_alu_4_bit_req_sequencer;

  typedef struct packed {
    logic [3:0] r;
    logic       v;
    logic       z;
    logic       c;
  } alu_o_t;

  typedef struct {
    string       name;
    logic [3:0]  r;
    logic        v, z, c, chk, mis;
    int unsigned tc, ec;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_tc = 0;
  int unsigned exp_ec = 0;
  exp_t sb[$];
  logic fault = 1'b0;

  // DUT with SETTLE_CYCLES=1
  logic       Resetb, req_valid, req_ready, req_AINV, req_BNEG;
  logic [3:0] req_A, req_B;
  logic [1:0] req_Opr;
  logic [3:0] alu_A, alu_B, alu_RESULT;
  logic       alu_AINV, alu_BNEG, alu_OVERFLOW, alu_ZERO, alu_COUT;
  logic [1:0] alu_Opr;
  logic       rsp_valid, rsp_ready, rsp_OVERFLOW, rsp_ZERO, rsp_COUT, rsp_checked, rsp_mismatch;
  logic [3:0] rsp_RESULT;
  logic [7:0] test_count, error_count;
  alu_o_t     alu_o1;

  // DUT with SETTLE_CYCLES=3
  logic       Resetb3, req_valid3, req_ready3, req_AINV3, req_BNEG3;
  logic [3:0] req_A3, req_B3;
  logic [1:0] req_Opr3;
  logic [3:0] alu_A3, alu_B3, alu_RESULT3;
  logic       alu_AINV3, alu_BNEG3, alu_OVERFLOW3, alu_ZERO3, alu_COUT3;
  logic [1:0] alu_Opr3;
  logic       rsp_valid3, rsp_ready3, rsp_OVERFLOW3, rsp_ZERO3, rsp_COUT3, rsp_checked3, rsp_mismatch3;
  logic [3:0] rsp_RESULT3;
  logic [7:0] test_count3, error_count3;
  alu_o_t     alu_o3;

  alu_4_bit_req_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
    .Clk(clk), .Resetb(Resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A), .req_B(req_B),
    .req_AINV(req_AINV), .req_BNEG(req_BNEG), .req_Opr(req_Opr),
    .alu_A(alu_A), .alu_B(alu_B), .alu_AINV(alu_AINV), .alu_BNEG(alu_BNEG), .alu_Opr(alu_Opr),
    .alu_RESULT(alu_RESULT), .alu_OVERFLOW(alu_OVERFLOW), .alu_ZERO(alu_ZERO), .alu_COUT(alu_COUT),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_RESULT(rsp_RESULT),
    .rsp_OVERFLOW(rsp_OVERFLOW), .rsp_ZERO(rsp_ZERO), .rsp_COUT(rsp_COUT),
    .rsp_checked(rsp_checked), .rsp_mismatch(rsp_mismatch),
    .test_count(test_count), .error_count(error_count)
  );

  alu_4_bit_req_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
    .Clk(clk), .Resetb(Resetb3),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_A(req_A3), .req_B(req_B3),
    .req_AINV(req_AINV3), .req_BNEG(req_BNEG3), .req_Opr(req_Opr3),
    .alu_A(alu_A3), .alu_B(alu_B3), .alu_AINV(alu_AINV3), .alu_BNEG(alu_BNEG3), .alu_Opr(alu_Opr3),
    .alu_RESULT(alu_RESULT3), .alu_OVERFLOW(alu_OVERFLOW3), .alu_ZERO(alu_ZERO3), .alu_COUT(alu_COUT3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_RESULT(rsp_RESULT3),
    .rsp_OVERFLOW(rsp_OVERFLOW3), .rsp_ZERO(rsp_ZERO3), .rsp_COUT(rsp_COUT3),
    .rsp_checked(rsp_checked3), .rsp_mismatch(rsp_mismatch3),
    .test_count(test_count3), .error_count(error_count3)
  );

  // Behavioural ripple ALU: AND, OR, ADD, XOR; flags come from the adder.
  function automatic alu_o_t alu_model(input logic [3:0] a, input logic [3:0] b,
                                       input logic ainv, input logic bneg,
                                       input logic [1:0] opr);
    logic [3:0] aa, bb;
    logic [4:0] s;
    alu_o_t     o;
    aa = ainv ? ~a : a;
    bb = bneg ? ~b : b;
    s  = {1'b0, aa} + {1'b0, bb} + {4'b0, bneg};
    case (opr)
      2'd0:    o.r = aa & bb;
      2'd1:    o.r = aa | bb;
      2'd2:    o.r = s[3:0];
      default: o.r = aa ^ bb;
    endcase
    o.c = s[4];
    o.v = (aa[3] == bb[3]) && (s[3] != aa[3]);
    o.z = (o.r == 4'd0);
    return o;
  endfunction

  always_comb begin
    alu_o1       = alu_model(alu_A, alu_B, alu_AINV, alu_BNEG, alu_Opr);
    alu_RESULT   = fault ? 4'b0000 : alu_o1.r;
    alu_OVERFLOW = alu_o1.v;
    alu_ZERO     = alu_o1.z;
    alu_COUT     = alu_o1.c;
    alu_o3        = alu_model(alu_A3, alu_B3, alu_AINV3, alu_BNEG3, alu_Opr3);
    alu_RESULT3   = alu_o3.r;
    alu_OVERFLOW3 = alu_o3.v;
    alu_ZERO3     = alu_o3.z;
    alu_COUT3     = alu_o3.c;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [3:0] r, input logic v, input logic z,
                          input logic c, input logic chk, input logic mis);
    exp_t e;
    exp_tc++;
    if (mis) exp_ec++;
    e.name = name; e.r = r; e.v = v; e.z = z; e.c = c; e.chk = chk; e.mis = mis;
    e.tc = exp_tc; e.ec = exp_ec;
    sb.push_back(e);
  endtask

  // Drives a request and returns just after the accepting edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic ainv,
                       input logic bneg, input logic [1:0] opr);
    int n;
    n = 0;
    req_A = a; req_B = b; req_AINV = ainv; req_BNEG = bneg; req_Opr = opr;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every response handshake against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.name, ".result"},   rsp_RESULT,   e.r);
          check({e.name, ".overflow"}, rsp_OVERFLOW, e.v);
          check({e.name, ".zero"},     rsp_ZERO,     e.z);
          check({e.name, ".cout"},     rsp_COUT,     e.c);
          check({e.name, ".checked"},  rsp_checked,  e.chk);
          check({e.name, ".mismatch"}, rsp_mismatch, e.mis);
          @(posedge clk);
          #1;
          check({e.name, ".test_count"},  test_count,  e.tc);
          check({e.name, ".error_count"}, error_count, e.ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    Resetb = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_A = '0; req_B = '0; req_AINV = 1'b0; req_BNEG = 1'b0; req_Opr = '0;
    Resetb3 = 1'b0; req_valid3 = 1'b0; rsp_ready3 = 1'b1;
    req_A3 = '0; req_B3 = '0; req_AINV3 = 1'b0; req_BNEG3 = 1'b0; req_Opr3 = '0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.alu",   {alu_A, alu_B, alu_AINV, alu_BNEG, alu_Opr}, 0);
    check("rst.rsp",   {rsp_valid, rsp_RESULT, rsp_OVERFLOW, rsp_ZERO, rsp_COUT,
                        rsp_checked, rsp_mismatch}, 0);
    check("rst.count", {test_count, error_count}, 0);
    check("rst.req_ready", req_ready, 0);
    Resetb = 1'b1;
    @(posedge clk);
    #1 check("rst.ready_after", req_ready, 1);

    // ADD 14+1 with latency check
    push_exp("add_14_1", 4'b1111, 0, 0, 0, 1, 0);
    issue(4'd14, 4'd1, 0, 0, 2'd2);
    check("add_14_1.alu_A", alu_A, 4'd14);
    @(negedge clk);
    check("add_14_1.lat_settle", rsp_valid, 0);
    @(negedge clk);
    check("add_14_1.lat_valid", rsp_valid, 1);
    wait_drain();

    push_exp("add_10_9", 4'b0011, 1, 0, 1, 1, 0);
    issue(4'd10, 4'd9, 0, 0, 2'd2);
    wait_drain();
    push_exp("sub_5_8", 4'b1101, 1, 0, 0, 1, 0);
    issue(4'd5, 4'd8, 0, 1, 2'd2);
    wait_drain();
    push_exp("sub_5_5", 4'b0000, 0, 1, 1, 1, 0);
    issue(4'd5, 4'd5, 0, 1, 2'd2);
    wait_drain();

    // RESULT forced to 0 during ADD 7+6 (true result 1101, V=1)
    fault = 1'b1;
    push_exp("fault_7_6", 4'b0000, 1, 0, 0, 1, 1);
    issue(4'd7, 4'd6, 0, 0, 2'd2);
    wait_drain();
    fault = 1'b0;

    // AND 12&10: unchecked, still counted
    push_exp("and_12_10", 4'b1000, 1, 0, 1, 0, 0);
    issue(4'd12, 4'd10, 0, 0, 2'd0);
    wait_drain();

    // Backpressure with a second request pending
    rsp_ready = 1'b0;
    push_exp("bp_2_3", 4'b0101, 0, 0, 0, 1, 0);
    issue(4'd2, 4'd3, 0, 0, 2'd2);
    push_exp("bp_1_1", 4'b0010, 0, 0, 0, 1, 0);
    req_A = 4'd1; req_B = 4'd1; req_AINV = 0; req_BNEG = 0; req_Opr = 2'd2;
    req_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.rsp_valid", rsp_valid, 1);
      check("bp.req_ready", req_ready, 0);
      check("bp.rsp_result", rsp_RESULT, 4'b0101);
      check("bp.alu_A", alu_A, 4'd2);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.idle_ready", req_ready, 1);
    check("bp.idle_rsp_valid", rsp_valid, 0);
    check("bp.not_yet", alu_A, 4'd2);
    @(posedge clk);
    #1;
    check("bp.accepted", alu_A, 4'd1);
    check("bp.busy", req_ready, 0);
    req_valid = 1'b0;
    wait_drain();

    // SETTLE_CYCLES=3: latency, then reset mid-SETTLE
    @(posedge clk);
    #1 Resetb3 = 1'b1;
    req_A3 = 4'd1; req_B3 = 4'd2; req_Opr3 = 2'd2; req_valid3 = 1'b1;
    @(negedge clk);
    check("s3.ready", req_ready3, 1);
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3.lat_settle", rsp_valid3, 0);
    end
    @(negedge clk);
    check("s3.lat_valid", rsp_valid3, 1);
    check("s3.result", rsp_RESULT3, 4'b0011);
    check("s3.mismatch", rsp_mismatch3, 0);
    @(posedge clk);
    #1 check("s3.test_count", test_count3, 1);

    req_valid3 = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    check("s3.accept2", req_ready3, 0);
    @(posedge clk);
    #1 Resetb3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 Resetb3 = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid3) seen = 1'b1;
    end
    check("s3.abandon_rsp", seen, 0);
    check("s3.abandon_tc", test_count3, 0);
    check("s3.abandon_ec", error_count3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
